iterative_left_shifter: RTL and testbench

- Multi-cycle left shifter for the KGP-RISC ALU; complements the combinational arithmetic right shifter.
- Computes a logical left shift of a 32-bit operand by a 5-bit amount using a log-stage iteration, one stage per clock.
- Flags signed overflow, meaning the result differs from inp * 2^shamt as a signed value.
- Used by the execute stage through a start/busy/done handshake.

---
 rtl/iterative_left_shifter.sv | 124 ++++++++++++
 tb/tb_iterative_left_shifter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/iterative_left_shifter.sv
// Multi-cycle logical left shifter: one log-stage per clock, fixed SHW-cycle latency,
// with a signed-overflow flag and a start/busy/done handshake.
module iterative_left_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam int unsigned KW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [SHW-1:0]   r_amt, w_amt_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic             r_sticky, w_sticky_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [SHW-1:0]   w_s;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_mask;
  logic             w_lost;
  logic [WIDTH-1:0] w_acc_stage;
  logic             w_sticky_stage;

  // Top s+1 bits are all equal iff no adjacent-bit difference falls in the top s positions.
  always_comb begin
    w_s            = SHW'(1) << r_k;
    w_diff         = r_acc ^ {r_acc[WIDTH-2:0], 1'b0};
    w_mask         = ~({WIDTH{1'b1}} >> w_s);
    w_lost         = |(w_diff & w_mask);
    w_acc_stage    = r_acc;
    w_sticky_stage = r_sticky;
    if (r_amt[r_k]) begin
      w_acc_stage    = r_acc << w_s;
      w_sticky_stage = r_sticky | w_lost;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_amt_nxt    = r_amt;
    w_k_nxt      = r_k;
    w_sticky_nxt = r_sticky;
    w_out_nxt    = r_out;
    w_ovf_nxt    = r_ovf;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_acc_nxt    = inp;
          w_amt_nxt    = shamt;
          w_k_nxt      = '0;
          w_sticky_nxt = 1'b0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        w_acc_nxt    = w_acc_stage;
        w_sticky_nxt = w_sticky_stage;
        w_k_nxt      = r_k + KW'(1);
        if (r_k == KW'(SHW - 1)) begin
          w_out_nxt   = w_acc_stage;
          w_ovf_nxt   = w_sticky_stage;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_amt    <= '0;
      r_k      <= '0;
      r_sticky <= 1'b0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_amt    <= w_amt_nxt;
      r_k      <= w_k_nxt;
      r_sticky <= w_sticky_nxt;
      r_out    <= w_out_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Directed bench for iterative_left_shifter: latency, results, overflow, handshake, reset abort.
module tb_iterative_left_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] inp;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_left_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inp   (inp),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single op: start pulsed one cycle, checks busy during E0..E4, done after E5, then hold.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                       input logic [31:0] exp_out, input logic exp_ovf);
    @(negedge clk);
    start = 1'b1; inp = a; shamt = sh;
    @(negedge clk);
    start = 1'b0; inp = 32'hDEAD_BEEF; shamt = 5'd17;
    chk({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    chk({tag, ".done0"}, {31'd0, done}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".done_early"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, ".out"}, out, exp_out);
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".out_hold"}, out, exp_out);
    chk({tag, ".ovf_hold"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inp = '0; shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.out", out, 32'd0);
    chk("rst.ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    do_op("full31",   32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
    do_op("neg4",     32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b0);
    do_op("neg31",    32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0);
    do_op("zero",     32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
    do_op("ovf_b1",   32'h4000_0000, 5'd1,  32'h8000_0000, 1'b1);
    do_op("ovf_b0",   32'h2000_0000, 5'd1,  32'h4000_0000, 1'b0);
    do_op("three30",  32'h0000_0003, 5'd30, 32'hC000_0000, 1'b1);

    // Handshake: start held high; mid-op operand changes must be ignored.
    @(negedge clk);
    start = 1'b1; inp = 32'h3; shamt = 5'd2;
    @(negedge clk);
    inp = 32'h0000_00FF; shamt = 5'd7;
    chk("hs1.busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("hs1.busy", {31'd0, busy}, 32'd1);
      chk("hs1.done_early", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("hs1.done", {31'd0, done}, 32'd1);
    chk("hs1.out", out, 32'h0000_000C);
    chk("hs1.ovf", {31'd0, ovf}, 32'd0);
    inp = 32'h5; shamt = 5'd3;
    @(negedge clk);
    start = 1'b0;
    chk("hs2.busy0", {31'd0, busy}, 32'd1);
    chk("hs2.done0", {31'd0, done}, 32'd0);
    chk("hs2.out_prev", out, 32'h0000_000C);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("hs2.busy", {31'd0, busy}, 32'd1);
      chk("hs2.out_prev", out, 32'h0000_000C);
    end
    @(negedge clk);
    chk("hs2.done", {31'd0, done}, 32'd1);
    chk("hs2.out", out, 32'h0000_0028);
    chk("hs2.ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    chk("hs2.done_pulse", {31'd0, done}, 32'd0);

    // Reset during stage 2 of 1<<8.
    start = 1'b1; inp = 32'h1; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.done", {31'd0, done}, 32'd0);
    chk("rstmid.out", out, 32'd0);
    chk("rstmid.ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstmid.no_done", {31'd0, done}, 32'd0);
      chk("rstmid.no_busy", {31'd0, busy}, 32'd0);
    end
    do_op("after_rst", 32'h0000_0001, 5'd8, 32'h0000_0100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
